// File: rtl/sram_port_arbiter.sv
// Single-port SRAM arbiter: CPU port A (r/w), video port B (read-only),
// plus a sequencer that zero-fills the whole array.
module sram_port_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_din,
    output logic                  a_ack,
    output logic                  a_valid,
    output logic [DATA_WIDTH-1:0] a_dout,
    input  logic                  b_req,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    output logic                  b_ack,
    output logic                  b_valid,
    output logic [DATA_WIDTH-1:0] b_dout,
    input  logic                  clr_start,
    output logic                  clr_busy,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_cen,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_q
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] CLEAR = 1'b1;
    localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);
    localparam logic [ADDR_WIDTH-1:0] CNT_ONE = ADDR_WIDTH'(1);

    logic [0:0]            state;
    logic [ADDR_WIDTH-1:0] clr_cnt;
    logic [3:0]            wait_cnt;
    logic                  a_pend;
    logic                  b_pend;
    logic [DATA_WIDTH-1:0] a_hold;
    logic [DATA_WIDTH-1:0] b_hold;
    logic                  idle_ok;
    logic                  a_win;
    logic                  b_win;

    assign idle_ok = (state == IDLE) && !rst;
    assign b_win   = idle_ok && b_req && (!a_req || wait_cnt == WAIT_LIM);
    assign a_win   = idle_ok && a_req && !b_win;

    assign a_ack    = a_win;
    assign b_ack    = b_win;
    assign clr_busy = (state == CLEAR);

    // Read data comes straight from the SRAM on the valid cycle, then is held.
    assign a_valid = a_pend;
    assign b_valid = b_pend;
    assign a_dout  = a_pend ? ram_q : a_hold;
    assign b_dout  = b_pend ? ram_q : b_hold;

    always_comb begin
        ram_cen  = 1'b0;
        ram_we   = 1'b0;
        ram_addr = a_addr;
        ram_data = a_din;
        if (!rst && state == CLEAR) begin
            ram_cen  = 1'b1;
            ram_we   = 1'b1;
            ram_addr = clr_cnt;
            ram_data = '0;
        end else if (b_win) begin
            ram_cen  = 1'b1;
            ram_addr = b_addr;
        end else if (a_win) begin
            ram_cen = 1'b1;
            ram_we  = a_we;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            clr_cnt  <= '0;
            wait_cnt <= '0;
            a_pend   <= 1'b0;
            b_pend   <= 1'b0;
            a_hold   <= '0;
            b_hold   <= '0;
        end else begin
            a_pend <= a_win && !a_we;
            b_pend <= b_win;
            if (a_pend) a_hold <= ram_q;
            if (b_pend) b_hold <= ram_q;
            unique case (state)
                IDLE: begin
                    if (b_req && !b_win) begin
                        if (wait_cnt != WAIT_LIM)
                            wait_cnt <= wait_cnt + 4'd1;
                    end else begin
                        wait_cnt <= '0;
                    end
                    if (clr_start) begin
                        state   <= CLEAR;
                        clr_cnt <= '0;
                    end
                end
                CLEAR: begin
                    clr_cnt <= clr_cnt + CNT_ONE;
                    if (&clr_cnt) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural SRAM and a
// queue-based scoreboard for read data.
module tb_sram_port_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_req, a_we, a_ack, a_valid;
    logic [9:0] a_addr;
    logic [7:0] a_din, a_dout;
    logic       b_req, b_ack, b_valid;
    logic [9:0] b_addr;
    logic [7:0] b_dout;
    logic       clr_start, clr_busy;
    logic [9:0] ram_addr;
    logic [7:0] ram_data, ram_q;
    logic       ram_cen, ram_we;

    sram_port_arbiter #(
        .DATA_WIDTH(8), .ADDR_WIDTH(10), .MAX_WAIT(4)
    ) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_din(a_din),
        .a_ack(a_ack), .a_valid(a_valid), .a_dout(a_dout),
        .b_req(b_req), .b_addr(b_addr),
        .b_ack(b_ack), .b_valid(b_valid), .b_dout(b_dout),
        .clr_start(clr_start), .clr_busy(clr_busy),
        .ram_addr(ram_addr), .ram_data(ram_data),
        .ram_cen(ram_cen), .ram_we(ram_we), .ram_q(ram_q)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_val(input int i);
        return 8'(i) ^ 8'h5A;
    endfunction

    logic       reinit;
    logic [7:0] mem [0:1023];

    always @(posedge clk) begin
        if (reinit) begin
            for (int i = 0; i < 1024; i++) mem[i] <= init_val(i);
        end else if (ram_cen) begin
            if (ram_we) mem[ram_addr] <= ram_data;
            else ram_q <= mem[ram_addr];
        end
    end

    logic [7:0] aq[$];
    logic [7:0] bq[$];
    logic chk_ack, exp_a, exp_b;
    logic chk_busy, exp_busy;
    logic chk_rst;
    logic done;
    int   n_pass, n_tot;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endfunction

    initial begin
        n_pass = 0;
        n_tot  = 0;
        forever begin
            @(negedge clk);
            if (chk_ack) begin
                chk("a_ack", a_ack, exp_a);
                chk("b_ack", b_ack, exp_b);
            end
            if (chk_busy) chk("clr_busy", clr_busy, exp_busy);
            if (chk_rst) begin
                chk("rst_a_valid", a_valid, 0);
                chk("rst_b_valid", b_valid, 0);
                chk("rst_a_dout", a_dout, 0);
                chk("rst_b_dout", b_dout, 0);
                chk("rst_clr_busy", clr_busy, 0);
                chk("rst_ram_cen", ram_cen, 0);
                chk("rst_ram_we", ram_we, 0);
            end
            if (a_valid) begin
                if (aq.size() == 0) chk("a_valid_unexpected", a_valid, 0);
                else chk("a_dout", a_dout, aq.pop_front());
            end
            if (b_valid) begin
                if (bq.size() == 0) chk("b_valid_unexpected", b_valid, 0);
                else chk("b_dout", b_dout, bq.pop_front());
            end
            if (done) begin
                chk("a_reads_missing", aq.size(), 0);
                chk("b_reads_missing", bq.size(), 0);
                $display("%0d/%0d checks passed", n_pass, n_tot);
                $finish;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
        chk_ack   = 1'b0;
        chk_busy  = 1'b0;
        chk_rst   = 1'b0;
        clr_start = 1'b0;
    endtask

    task automatic want(input logic ea, input logic eb);
        chk_ack = 1'b1;
        exp_a   = ea;
        exp_b   = eb;
    endtask

    task automatic want_busy(input logic eb);
        chk_busy = 1'b1;
        exp_busy = eb;
    endtask

    logic [1:0] pat [6];
    int         rb_addr [7];
    logic [7:0] rb_exp [7];

    initial begin
        chk_ack = 0; exp_a = 0; exp_b = 0;
        chk_busy = 0; exp_busy = 0; chk_rst = 0; done = 0;
        rst = 1; reinit = 1;
        a_req = 1; a_we = 0; a_addr = 10'h005; a_din = 0;
        b_req = 1; b_addr = 10'h010; clr_start = 0;
        step();
        step();
        want(0, 0);
        chk_rst = 1;
        step();
        rst = 0; reinit = 0; a_req = 0; b_req = 0;
        step();

        // A read after reset
        a_req = 1; a_we = 0; a_addr = 10'h005;
        want(1, 0); aq.push_back(init_val(5));
        step();

        // A write then read of the top word
        a_we = 1; a_addr = 10'h3FF; a_din = 8'hA5;
        want(1, 0);
        step();
        a_we = 0;
        want(1, 0); aq.push_back(8'hA5);
        step();
        a_req = 0;
        step();

        // B only, then contention with a zero wait count
        b_req = 1; b_addr = 10'h010;
        want(0, 1); bq.push_back(init_val(16));
        step();
        a_req = 1; a_addr = 10'h020;
        want(1, 0); aq.push_back(init_val(32));
        step();
        a_req = 0; b_req = 0;
        step();

        // Starvation override: A x4, B, A
        pat = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10};
        a_req = 1; a_addr = 10'h020; b_req = 1; b_addr = 10'h030;
        for (int i = 0; i < 6; i++) begin
            want(pat[i][1], pat[i][0]);
            if (pat[i][1]) aq.push_back(init_val(32));
            else bq.push_back(init_val(48));
            step();
        end
        a_req = 0; b_req = 0;
        step();

        // Clear with A held; a restart pulse mid-clear is ignored
        a_req = 1; a_we = 0; a_addr = 10'h005; clr_start = 1;
        want(1, 0); aq.push_back(init_val(5));
        step();
        for (int k = 0; k < 1024; k++) begin
            if (k == 500) clr_start = 1;
            want(0, 0); want_busy(1);
            step();
        end
        want(1, 0); want_busy(0); aq.push_back(8'h00);
        step();
        for (int i = 0; i < 1024; i++) begin
            a_addr = 10'(i);
            want(1, 0); aq.push_back(8'h00);
            step();
        end
        a_req = 0;
        step();

        // Reset at clear cycle 100
        reinit = 1;
        step();
        reinit = 0; clr_start = 1;
        step();
        for (int k = 0; k < 100; k++) begin
            want_busy(1);
            step();
        end
        rst = 1;
        want(0, 0);
        step();
        rst = 0;
        want_busy(0);
        step();
        rb_addr = '{0, 50, 99, 100, 101, 500, 1023};
        rb_exp  = '{8'h00, 8'h00, 8'h00, init_val(100), init_val(101),
                    init_val(500), init_val(1023)};
        a_req = 1; a_we = 0;
        for (int i = 0; i < 7; i++) begin
            a_addr = 10'(rb_addr[i]);
            want(1, 0); aq.push_back(rb_exp[i]);
            step();
        end
        a_req = 0;
        step();
        step();
        done = 1;
    end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Shares one single-port synchronous SRAM (1-cycle read latency, write on `cen && we`) between a CPU port (A, read/write) and a video fetch port (B, read-only). It also contains a clear sequencer that zero-fills the whole array on request. It sits between the CPU/video address decoders and one SRAM instance, and drives all of that SRAM's inputs.

## Interface
- `DATA_WIDTH`, 8, data width of the SRAM and both ports
- `ADDR_WIDTH`, 10, address width; the array holds 2^ADDR_WIDTH words
- `MAX_WAIT`, 4, consecutive denied cycles after which port B overrides port A (range 1–15)

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge
- `rst`  in  1  synchronous, active-high reset
- `a_req`  in  1  port A request; held with `a_we`/`a_addr`/`a_din` stable until `a_ack`
- `a_we`  in  1  1 = write, 0 = read
- `a_addr`  in  ADDR_WIDTH  port A address
- `a_din`  in  DATA_WIDTH  port A write data
- `a_ack`  out  1  port A access performed this cycle
- `a_valid`  out  1  one-cycle pulse; `a_dout` holds read data
- `a_dout`  out  DATA_WIDTH  port A read data
- `b_req`  in  1  port B read request; held with `b_addr` until `b_ack`
- `b_addr`  in  ADDR_WIDTH  port B address
- `b_ack`  out  1  port B access performed this cycle
- `b_valid`  out  1  one-cycle pulse; `b_dout` holds read data
- `b_dout`  out  DATA_WIDTH  port B read data
- `clr_start`  in  1  one-cycle pulse that starts a full-array zero fill
- `clr_busy`  out  1  high while the clear sequence runs
- `ram_addr`  out  ADDR_WIDTH  SRAM address
- `ram_data`  out  DATA_WIDTH  SRAM write data
- `ram_cen`  out  1  SRAM enable
- `ram_we`  out  1  SRAM write enable
- `ram_q`  in  DATA_WIDTH  SRAM registered read data

## Operation
- State machine has two states: IDLE and CLEAR. Reset enters IDLE.
- In IDLE, at most one grant per cycle, decided combinationally from the current requests and registered state:
  - B wins if `b_req` is high and (`a_req` is low, or `wait_cnt == MAX_WAIT`).
  - Otherwise A wins if `a_req` is high.
- `wait_cnt` (4-bit) behaviour each IDLE cycle:
  - Increments when `b_req` is high and B is not granted; saturates at `MAX_WAIT`.
  - Clears to 0 when B is granted or `b_req` is low.
- On a grant in cycle N:
  - `ram_cen` = 1 and `ram_addr` = the winner's address.
  - `ram_we` = `a_we` if A wins, 0 if B wins; `ram_data` = `a_din`.
  - The winner's ack is high in cycle N.
- With no grant: `ram_cen` = 0, `ram_we` = 0, `ram_addr` = `a_addr`.
- Read grant in cycle N: in cycle N+1 the winner's `*_valid` = 1 and `*_dout` = `ram_q`. `*_dout` holds its value until the next valid pulse.
- A write grant produces no `a_valid` pulse.
- `clr_start` in IDLE:
  - The next cycle enters CLEAR with `clr_cnt` = 0.
  - A grant made in the same cycle as `clr_start` still completes.
- In CLEAR, each cycle:
  - `ram_cen` = 1, `ram_we` = 1, `ram_addr` = `clr_cnt`, `ram_data` = 0; then `clr_cnt` increments.
  - No acks; `wait_cnt` holds.
  - After the write to address 2^ADDR_WIDTH−1, return to IDLE.
- `clr_start` during CLEAR is ignored; the clear is not restarted.
- Requests held during CLEAR are served in the first IDLE cycle under the normal priority rules.

## Timing
- Reset values: state IDLE, `clr_cnt` = 0, `wait_cnt` = 0, `clr_busy` = 0, `a_valid` = `b_valid` = 0, `a_dout` = `b_dout` = 0.
- While `rst` is high, `a_ack`, `b_ack`, `ram_cen` and `ram_we` are forced to 0.
- Reset asserted mid-CLEAR aborts the clear; the next cycle is IDLE with `clr_busy` = 0.
- Acks are combinational (same cycle as request). Read latency is 1 cycle from ack to valid.
- Throughput is one access per cycle; back-to-back grants to the same or alternating ports are allowed.
- `clr_busy` is registered: it goes high the cycle after `clr_start` and stays high for exactly 2^ADDR_WIDTH cycles.
- A write to address X in cycle N followed by a read of X in cycle N+1 returns the new data.

## Test plan
- **A read after reset:** `a_req`=1, `a_we`=0, `a_addr`=0x005 → `a_ack` in the same cycle; next cycle `a_valid`=1 and `a_dout` = mem[5].
- **A write then read:** write 0xA5 to 0x3FF, then read 0x3FF the next cycle → `a_dout`=0xA5 with no `a_valid` on the write cycle.
- **Starvation override:** `a_req` and `b_req` held continuously (A doing reads), `MAX_WAIT`=4 → A acked 4 cycles, B acked in the 5th cycle, then A again; no cycle has both acks.
- **B only:** `b_req`=1, `b_addr`=0x010 → `b_ack` immediately; `b_valid` next cycle with mem[0x010]; `wait_cnt` stays 0.
- **Clear:** `clr_start` pulse with `a_req` held → `clr_busy` high for 1024 cycles, all words read back 0x00, `a_ack` asserted in the first cycle after `clr_busy` falls.
- **Reset mid-clear:** `rst` at clear cycle 100 → `clr_busy`=0 the next cycle; words 0–99 are 0x00 and word 100 onward keep their init contents.
